// File: rtl/vga_scan_controller_pkg.sv
// Shared VGA timing defaults, the sync-flag bundle passed from the scan counter to the
// output pipeline, and a counter-width helper.
package vga_scan_controller_pkg;

    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;
    localparam int VGA_CLK_DIV   = 2;
    localparam int VGA_ADDR_W    = 24;

    // Sync flags are active-high internally; the pins invert them at the output register.
    typedef struct packed {
        logic visible;
        logic hsync;
        logic vsync;
    } scan_flags_t;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Pixel-rate divider plus horizontal/vertical scan counters; decodes visible area and
// sync windows from the current scan position.
module vga_sync_counter
    import vga_scan_controller_pkg::*;
#(
    parameter int H_VISIBLE = VGA_H_VISIBLE,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_VISIBLE = VGA_V_VISIBLE,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK,
    parameter int CLK_DIV   = VGA_CLK_DIV
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        tick,
    output logic        frame_wrap,
    output scan_flags_t flags
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = cnt_w(CLK_DIV);
    localparam int H_W     = cnt_w(H_TOTAL);
    localparam int V_W     = cnt_w(V_TOTAL);

    logic [DIV_W-1:0] div_p0;
    logic [H_W-1:0]   h_count_p0;
    logic [V_W-1:0]   v_count_p0;
    logic             h_last;
    logic             v_last;

    assign tick       = (div_p0 == DIV_W'(CLK_DIV - 1));
    assign h_last     = (h_count_p0 == H_W'(H_TOTAL - 1));
    assign v_last     = (v_count_p0 == V_W'(V_TOTAL - 1));
    assign frame_wrap = tick && h_last && v_last;

    // Stage 0: scan position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_p0     <= '0;
            h_count_p0 <= '0;
            v_count_p0 <= '0;
        end else begin
            div_p0 <= tick ? '0 : div_p0 + DIV_W'(1);
            if (tick) begin
                if (h_last) begin
                    h_count_p0 <= '0;
                    v_count_p0 <= v_last ? '0 : v_count_p0 + V_W'(1);
                end else begin
                    h_count_p0 <= h_count_p0 + H_W'(1);
                end
            end
        end
    end

    always_comb begin
        flags.visible = (h_count_p0 < H_W'(H_VISIBLE)) && (v_count_p0 < V_W'(V_VISIBLE));
        flags.hsync   = (h_count_p0 >= H_W'(H_VISIBLE + H_FRONT)) &&
                        (h_count_p0 <  H_W'(H_VISIBLE + H_FRONT + H_SYNC));
        flags.vsync   = (v_count_p0 >= V_W'(V_VISIBLE + V_FRONT)) &&
                        (v_count_p0 <  V_W'(V_VISIBLE + V_FRONT + V_SYNC));
    end

endmodule

// File: rtl/vga_scan_controller.sv
// VGA 640x480@60 scan controller: issues linear video-RAM read addresses and turns the
// returned pixel into blanked RGB plus HS/VS, all aligned three clocks behind the counters.
module vga_scan_controller
    import vga_scan_controller_pkg::*;
#(
    parameter int H_VISIBLE = VGA_H_VISIBLE,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_VISIBLE = VGA_V_VISIBLE,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK,
    parameter int CLK_DIV   = VGA_CLK_DIV,
    parameter int ADDR_W    = VGA_ADDR_W
) (
    input  logic              Clock,
    input  logic              Reset,
    output logic [ADDR_W-1:0] oReadAddress,
    input  logic [2:0]        iPixel,
    output logic              oVGA_R,
    output logic              oVGA_G,
    output logic              oVGA_B,
    output logic              oVGA_HS,
    output logic              oVGA_VS,
    output logic              oFrameStart
);

    // Holds one past the last visible pixel during vertical blanking, hence the full count.
    localparam int PIX_W = cnt_w(H_VISIBLE * V_VISIBLE + 1);

    logic             tick;
    logic             frame_wrap;
    scan_flags_t      flags_p0;
    scan_flags_t      flags_p1;
    scan_flags_t      flags_p2;
    logic [PIX_W-1:0] addr_p0;
    logic             fs_p0;
    logic             fs_p1;
    logic             fs_p2;

    vga_sync_counter #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK),
        .CLK_DIV   (CLK_DIV)
    ) u_sync (
        .clk        (Clock),
        .rst_n      (Reset),
        .tick       (tick),
        .frame_wrap (frame_wrap),
        .flags      (flags_p0)
    );

    // Stage 0: running pixel address tracks v*H_VISIBLE+h without a multiplier
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            addr_p0 <= '0;
            fs_p0   <= 1'b0;
        end else begin
            if (tick) begin
                if (frame_wrap) begin
                    addr_p0 <= '0;
                end else if (flags_p0.visible) begin
                    addr_p0 <= addr_p0 + PIX_W'(1);
                end
            end
            // Only a real wrap marks a frame start, so the first frame after reset is silent.
            fs_p0 <= frame_wrap;
        end
    end

    // Stage 1: address register; Stage 2: RAM returns data; Stage 3: output registers
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            oReadAddress             <= '0;
            flags_p1                 <= '0;
            fs_p1                    <= 1'b0;
            flags_p2                 <= '0;
            fs_p2                    <= 1'b0;
            {oVGA_R, oVGA_G, oVGA_B} <= 3'b000;
            oVGA_HS                  <= 1'b1;
            oVGA_VS                  <= 1'b1;
            oFrameStart              <= 1'b0;
        end else begin
            oReadAddress             <= ADDR_W'(addr_p0);
            flags_p1                 <= flags_p0;
            fs_p1                    <= fs_p0;
            flags_p2                 <= flags_p1;
            fs_p2                    <= fs_p1;
            {oVGA_R, oVGA_G, oVGA_B} <= flags_p2.visible ? iPixel : 3'b000;
            oVGA_HS                  <= ~flags_p2.hsync;
            oVGA_VS                  <= ~flags_p2.vsync;
            oFrameStart              <= fs_p2;
        end
    end

endmodule
